lookup_engine: RTL and testbench

Match-action lookup stage directly downstream of key extraction in each pipeline stage. Takes the extracted key, key mask, condition flag and PHV, performs a ternary match against a 16-entry software-written table, and emits the winning action word with the PHV delayed to stay aligned. Output feeds the action engine of the same stage. Hit/miss statistics counters are kept for the control plane.

---
 rtl/lookup_pkg.sv | 14 +
 rtl/lookup_prio_enc.sv | 18 +
 rtl/lookup_engine.sv | 128 ++++++++++++
 tb/tb_lookup_engine.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lookup_pkg.sv
// lookup_pkg: shared widths, counter width and helpers for the lookup stage
package lookup_pkg;
  localparam int KEY_LEN = 896;
  localparam int MASK_LEN = 896;
  localparam int PHV_LEN = 1579;
  localparam int ACT_LEN = 625;
  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 32;
  localparam logic [ACT_LEN-1:0] MISS_ACT = '0;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/lookup_prio_enc.sv
// lookup_prio_enc: match vector to {hit, index}, lowest index wins
module lookup_prio_enc
  import lookup_pkg::*;
#(
  parameter int N = DEPTH,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] match_i,
  output logic         hit_o,
  output logic [W-1:0] idx_o
);
  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    hit_o = |match_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = match_i[i] ? W'(i) : idx_o;
  end
endmodule

// File: rtl/lookup_engine.sv
// lookup_engine: 3-stage ternary match-action lookup with hit/miss statistics
module lookup_engine #(
  parameter int KEY_LEN = lookup_pkg::KEY_LEN,
  parameter int MASK_LEN = lookup_pkg::MASK_LEN,
  parameter int PHV_LEN = lookup_pkg::PHV_LEN,
  parameter int ACT_LEN = lookup_pkg::ACT_LEN,
  parameter int DEPTH = lookup_pkg::DEPTH,
  parameter int STAGE = 0
) (
  input  logic                     axis_clk,
  input  logic                     areset,
  input  logic                     key_valid,
  input  logic [KEY_LEN-1:0]       extract_key,
  input  logic                     key_mask_valid,
  input  logic [MASK_LEN-1:0]      key_mask,
  input  logic                     cond_flag,
  input  logic [PHV_LEN-1:0]       pkt_hdr_vec_in,
  input  logic                     cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0] cfg_wr_idx,
  input  logic                     cfg_wr_vld,
  input  logic [KEY_LEN-1:0]       cfg_wr_key,
  input  logic [MASK_LEN-1:0]      cfg_wr_mask,
  input  logic [ACT_LEN-1:0]       cfg_wr_act,
  input  logic                     cnt_clr,
  output logic                     action_valid,
  output logic [ACT_LEN-1:0]       action,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic [PHV_LEN-1:0]       pkt_hdr_vec_out,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
);
  import lookup_pkg::*;
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0]    ent_vld_q;
  logic [KEY_LEN-1:0]  ent_key_q  [DEPTH];
  logic [MASK_LEN-1:0] ent_mask_q [DEPTH];
  logic [ACT_LEN-1:0]  ent_act_q  [DEPTH];
  logic                s1_vld_q, s1_cond_q;
  logic [KEY_LEN-1:0]  s1_key_q;
  logic [MASK_LEN-1:0] s1_mask_q;
  logic [PHV_LEN-1:0]  s1_phv_q;
  logic [DEPTH-1:0]    match_d;
  logic                pe_hit, s2_hit_d;
  logic [IW-1:0]       pe_idx, s2_idx_d;
  logic [ACT_LEN-1:0]  s2_act_d;
  logic                s2_vld_q, s2_hit_q;
  logic [IW-1:0]       s2_idx_q;
  logic [ACT_LEN-1:0]  s2_act_q;
  logic [PHV_LEN-1:0]  s2_phv_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
  // entry valid bits are reset so the table comes up empty
  always_ff @(posedge axis_clk)
    if (areset) ent_vld_q <= '0;
    else if (cfg_wr_en) ent_vld_q[cfg_wr_idx] <= cfg_wr_vld;
  // entry contents are plain storage, only meaningful once the valid bit is set
  always_ff @(posedge axis_clk)
    if (cfg_wr_en) begin
      ent_key_q[cfg_wr_idx]  <= cfg_wr_key;
      ent_mask_q[cfg_wr_idx] <= cfg_wr_mask;
      ent_act_q[cfg_wr_idx]  <= cfg_wr_act;
    end
  // S1 valid
  always_ff @(posedge axis_clk) s1_vld_q <= areset ? 1'b0 : key_valid;
  // S1 data: key, effective lookup mask, condition and PHV
  always_ff @(posedge axis_clk)
    if (key_valid) begin
      s1_key_q  <= extract_key;
      s1_mask_q <= key_mask_valid ? key_mask : '1;
      s1_cond_q <= cond_flag;
      s1_phv_q  <= pkt_hdr_vec_in;
    end
  // S2 compare: the table is read here, so writes up to the S1 load edge are seen
  always_comb begin
    match_d = '0;
    for (int i = 0; i < DEPTH; i++)
      match_d[i] = ent_vld_q[i] && (((s1_key_q ^ ent_key_q[i]) & ent_mask_q[i] & s1_mask_q) == '0);
  end
  lookup_prio_enc #(.N(DEPTH), .W(IW)) u_prio (
    .match_i (match_d),
    .hit_o   (pe_hit),
    .idx_o   (pe_idx)
  );
  // a cleared condition flag turns any match into a miss
  always_comb begin
    s2_hit_d = pe_hit & s1_cond_q;
    s2_idx_d = s2_hit_d ? pe_idx : '0;
    s2_act_d = s2_hit_d ? ent_act_q[pe_idx] : ACT_LEN'(MISS_ACT);
  end
  // S2 valid
  always_ff @(posedge axis_clk) s2_vld_q <= areset ? 1'b0 : s1_vld_q;
  // S2 data: lookup result and PHV carried alongside
  always_ff @(posedge axis_clk)
    if (s1_vld_q) begin
      s2_hit_q <= s2_hit_d;
      s2_idx_q <= s2_idx_d;
      s2_act_q <= s2_act_d;
      s2_phv_q <= s1_phv_q;
    end
  // S3 output registers hold the last result between lookups
  always_ff @(posedge axis_clk)
    if (areset) begin
      action_valid    <= 1'b0;
      action          <= '0;
      hit             <= 1'b0;
      hit_idx         <= '0;
      pkt_hdr_vec_out <= '0;
    end else begin
      action_valid <= s2_vld_q;
      if (s2_vld_q) begin
        action          <= s2_act_q;
        hit             <= s2_hit_q;
        hit_idx         <= s2_idx_q;
        pkt_hdr_vec_out <= s2_phv_q;
      end
    end
  // statistics move on the same edge the result reaches the outputs; clear wins
  always_ff @(posedge axis_clk)
    if (areset || cnt_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (s2_vld_q) begin
      if (s2_hit_q) hit_cnt_q <= sat_inc(hit_cnt_q);
      else miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_lookup_engine.sv
// tb_lookup_engine: directed and random lookups checked against a table model
module tb_lookup_engine;
  localparam int KL = 896;
  localparam int PL = 1579;
  localparam int AL = 625;
  localparam int D = 16;
  typedef struct {
    int due;
    logic hit;
    logic [3:0] idx;
    logic [AL-1:0] act;
    logic [PL-1:0] phv;
  } res_t;
  logic clk = 0;
  logic areset, key_valid, key_mask_valid, cond_flag, cfg_wr_en, cfg_wr_vld, cnt_clr;
  logic [KL-1:0] extract_key, key_mask, cfg_wr_key, cfg_wr_mask;
  logic [PL-1:0] pkt_hdr_vec_in, pkt_hdr_vec_out;
  logic [3:0] cfg_wr_idx, hit_idx;
  logic [AL-1:0] cfg_wr_act, action;
  logic action_valid, hit;
  logic [31:0] hit_cnt, miss_cnt;
  logic m_vld [D];
  logic [KL-1:0] m_key [D], m_mask [D];
  logic [AL-1:0] m_act [D];
  res_t q[$];
  logic e_av, e_hit;
  logic [3:0] e_idx;
  logic [AL-1:0] e_act;
  logic [PL-1:0] e_phv;
  logic [31:0] e_hc, e_mc;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [KL-1:0] K, K0, K1, K2, K3, kp [4];
  logic [AL-1:0] A;
  lookup_engine dut (
    .axis_clk(clk), .areset(areset), .key_valid(key_valid), .extract_key(extract_key),
    .key_mask_valid(key_mask_valid), .key_mask(key_mask), .cond_flag(cond_flag),
    .pkt_hdr_vec_in(pkt_hdr_vec_in), .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_vld(cfg_wr_vld), .cfg_wr_key(cfg_wr_key), .cfg_wr_mask(cfg_wr_mask),
    .cfg_wr_act(cfg_wr_act), .cnt_clr(cnt_clr), .action_valid(action_valid),
    .action(action), .hit(hit), .hit_idx(hit_idx), .pkt_hdr_vec_out(pkt_hdr_vec_out),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [1599:0] rbits();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
  function automatic res_t lookup_model();
    res_t r;
    logic [KL-1:0] em;
    em = key_mask_valid ? key_mask : '1;
    r.hit = 0; r.idx = 0; r.act = '0; r.phv = pkt_hdr_vec_in; r.due = 0;
    for (int i = 0; i < D; i++)
      if (!r.hit && m_vld[i] && (((extract_key ^ m_key[i]) & m_mask[i] & em) == '0)) begin
        r.hit = 1; r.idx = 4'(i); r.act = m_act[i];
      end
    if (!cond_flag) begin r.hit = 0; r.idx = 0; r.act = '0; end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [PL-1:0] o, input logic [PL-1:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %0h exp %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    res_t r;
    @(posedge clk);
    if (areset) begin
      for (int i = 0; i < D; i++) m_vld[i] = 0;
      q.delete();
      e_av = 0; e_hit = 0; e_idx = 0; e_act = '0; e_phv = '0; e_hc = 0; e_mc = 0;
    end else begin
      e_av = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        e_av = 1; e_hit = r.hit; e_idx = r.idx; e_act = r.act; e_phv = r.phv;
        if (r.hit) e_hc = sat(e_hc); else e_mc = sat(e_mc);
      end
      if (cnt_clr) begin e_hc = 0; e_mc = 0; end
      if (cfg_wr_en) begin
        m_vld[cfg_wr_idx] = cfg_wr_vld; m_key[cfg_wr_idx] = cfg_wr_key;
        m_mask[cfg_wr_idx] = cfg_wr_mask; m_act[cfg_wr_idx] = cfg_wr_act;
      end
      if (key_valid) begin
        r = lookup_model();
        r.due = cyc + 2;
        q.push_back(r);
      end
    end
    cyc++;
    @(negedge clk);
    chk("action_valid", PL'(action_valid), PL'(e_av));
    chk("hit", PL'(hit), PL'(e_hit));
    chk("hit_idx", PL'(hit_idx), PL'(e_idx));
    chk("action", PL'(action), PL'(e_act));
    chk("phv_out", pkt_hdr_vec_out, e_phv);
    chk("hit_cnt", PL'(hit_cnt), PL'(e_hc));
    chk("miss_cnt", PL'(miss_cnt), PL'(e_mc));
    key_valid = 0; cfg_wr_en = 0; cnt_clr = 0; areset = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wr(input logic [3:0] idx, input logic v, input logic [KL-1:0] k,
                    input logic [KL-1:0] m, input logic [AL-1:0] a);
    cfg_wr_en = 1; cfg_wr_idx = idx; cfg_wr_vld = v; cfg_wr_key = k; cfg_wr_mask = m; cfg_wr_act = a;
  endtask
  task automatic lk(input logic [KL-1:0] k, input logic kmv, input logic [KL-1:0] km, input logic c);
    key_valid = 1; extract_key = k; key_mask_valid = kmv; key_mask = km; cond_flag = c;
    pkt_hdr_vec_in = PL'(rbits());
  endtask
  initial begin
    areset = 1; key_valid = 0; key_mask_valid = 0; cond_flag = 0; cfg_wr_en = 0; cfg_wr_vld = 0;
    cnt_clr = 0; extract_key = '0; key_mask = '0; pkt_hdr_vec_in = '0; cfg_wr_idx = 0;
    cfg_wr_key = '0; cfg_wr_mask = '0; cfg_wr_act = '0;
    tick();
    areset = 1; tick();
    K = KL'(rbits()); A = AL'(rbits());
    wr(3, 1, K, '1, A); tick();
    lk(K, 0, '0, 1); idle(4);
    K2 = KL'(rbits());
    wr(2, 1, K2, '1, AL'(rbits())); tick();
    wr(5, 1, KL'(rbits()), '0, AL'(rbits())); tick();
    lk(K2, 0, '0, 1); tick();
    wr(2, 0, K2, '1, AL'(rbits())); tick();
    lk(K2, 0, '0, 1); idle(3);
    wr(5, 0, '0, '0, '0); tick();
    K0 = KL'(rbits());
    wr(0, 1, K0, '1, AL'(rbits())); tick();
    lk(K0 ^ ~KL'(16'hFFFF), 1, KL'(16'hFFFF), 1); tick();
    lk(K0 ^ ~KL'(16'hFFFF), 0, KL'(16'hFFFF), 1); idle(3);
    lk(K, 0, '0, 0); idle(3);
    K1 = KL'(rbits()); K2 = KL'(rbits()); K3 = KL'(rbits());
    wr(8, 1, K1, '1, AL'(rbits())); tick();
    wr(9, 1, K2, '1, AL'(rbits())); tick();
    wr(10, 1, K3, '1, AL'(rbits())); tick();
    lk(K1, 0, '0, 1); tick();
    lk(K2, 0, '0, 1); wr(9, 1, K2, '1, AL'(rbits())); tick();
    lk(K3, 0, '0, 1); idle(4);
    lk(K, 0, '0, 1); tick(); tick();
    cnt_clr = 1; idle(3);
    for (int j = 0; j < 4; j++) kp[j] = KL'(rbits());
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 3)
        wr(4'($urandom_range(0, D - 1)), $urandom_range(0, 5) != 0, kp[$urandom_range(0, 3)],
           $urandom_range(0, 1) ? '1 : KL'(rbits()), AL'(rbits()));
      if ($urandom_range(0, 9) < 8)
        lk(kp[$urandom_range(0, 3)] ^ ($urandom_range(0, 1) ? KL'(1) << $urandom_range(0, KL - 1) : '0),
           1'($urandom_range(0, 1)), KL'(rbits()), $urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 30) == 0);
      tick();
    end
    idle(3);
    dut.miss_cnt_q = 32'hFFFF_FFFD; e_mc = 32'hFFFF_FFFD;
    for (int n = 0; n < 4; n++) begin
      lk(KL'(rbits()), 0, '0, 0); tick();
    end
    idle(3);
    lk(K, 0, '0, 1); tick();
    lk(K, 0, '0, 1); tick();
    areset = 1; idle(5);
    lk(K, 0, '0, 1); idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
